// File: rtl/wb_ctrl_pkg.sv
// Shared constants for the writeback controller: widths, load funct3
// encodings and the controller state type.
package wb_ctrl_pkg;

    localparam int DEF_CPU_WIDTH      = 64;
    localparam int DEF_REG_ADDR_WIDTH = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_ctrl_load_extend.sv
// load_extend: combinational byte/half/word extraction from an aligned
// doubleword plus sign/zero extension and an alignment check.
// Ports: dword_i (memory doubleword), type_i (load funct3),
//        addr_lo_i (address bits [2:0]) -> data_o (extended), aligned_o.
module load_extend
    import wb_ctrl_pkg::*;
#(
    parameter int W = DEF_CPU_WIDTH
) (
    input  logic [W-1:0] dword_i,
    input  logic [2:0]   type_i,
    input  logic [2:0]   addr_lo_i,
    output logic [W-1:0] data_o,
    output logic         aligned_o
);

    logic [W-1:0] shifted;

    // Bring the addressed byte lane down to bit 0.
    assign shifted = dword_i >> {addr_lo_i, 3'b000};

    always_comb begin
        data_o    = shifted;
        aligned_o = (addr_lo_i == 3'b000);
        unique case (type_i)
            F3_LB: begin
                data_o    = {{(W-8){shifted[7]}}, shifted[7:0]};
                aligned_o = 1'b1;
            end
            F3_LBU: begin
                data_o    = {{(W-8){1'b0}}, shifted[7:0]};
                aligned_o = 1'b1;
            end
            F3_LH: begin
                data_o    = {{(W-16){shifted[15]}}, shifted[15:0]};
                aligned_o = ~addr_lo_i[0];
            end
            F3_LHU: begin
                data_o    = {{(W-16){1'b0}}, shifted[15:0]};
                aligned_o = ~addr_lo_i[0];
            end
            F3_LW: begin
                data_o    = {{(W-32){shifted[31]}}, shifted[31:0]};
                aligned_o = (addr_lo_i[1:0] == 2'b00);
            end
            F3_LWU: begin
                data_o    = {{(W-32){1'b0}}, shifted[31:0]};
                aligned_o = (addr_lo_i[1:0] == 2'b00);
            end
            // LD and the unused 111 encoding pass the doubleword through.
            default: begin
                data_o    = shifted;
                aligned_o = (addr_lo_i == 3'b000);
            end
        endcase
    end

endmodule

// File: rtl/wb_ctrl.sv
// wb_ctrl: writeback controller between execute/LSU and the register file.
// Ports: ex_* retiring-instruction handshake, mem_rvalid/mem_rdata load
//        response, rs1/rs2_addr from decode -> load_hazard, reg_* write port,
//        err_misalign (pulse), err_unexp_rsp (sticky).
module wb_ctrl
    import wb_ctrl_pkg::*;
#(
    parameter int CPU_WIDTH      = DEF_CPU_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic                      ex_wen,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic [CPU_WIDTH-1:0]      ex_result,
    input  logic                      ex_is_load,
    input  logic [2:0]                ex_load_type,
    input  logic [2:0]                ex_addr_lo,
    input  logic                      mem_rvalid,
    input  logic [CPU_WIDTH-1:0]      mem_rdata,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic                      load_hazard,
    output logic                      reg_wen,
    output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
    output logic [CPU_WIDTH-1:0]      reg_wdata,
    output logic [7:0]                wmask,
    output logic                      err_misalign,
    output logic                      err_unexp_rsp
);

    wb_state_e                 state_q,     state_d;
    logic [REG_ADDR_WIDTH-1:0] ld_rd_q,     ld_rd_d;
    logic [2:0]                ld_type_q,   ld_type_d;
    logic [2:0]                ld_addr_q,   ld_addr_d;
    logic                      ld_wen_q,    ld_wen_d;
    logic                      reg_wen_q,   reg_wen_d;
    logic [REG_ADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
    logic [CPU_WIDTH-1:0]      reg_wdata_q, reg_wdata_d;
    logic                      err_mis_q,   err_mis_d;
    logic                      err_unexp_q, err_unexp_d;

    logic                 waiting;
    logic                 accept;
    logic [2:0]           ext_type;
    logic [2:0]           ext_addr;
    logic [CPU_WIDTH-1:0] ext_data;
    logic                 ext_aligned;

    assign waiting = (state_q == ST_WAIT_LOAD);
    assign accept  = ex_valid & ~waiting;

    // One extender serves both phases: while idle it checks the incoming
    // load's alignment, while waiting it formats the response.
    assign ext_type = waiting ? ld_type_q : ex_load_type;
    assign ext_addr = waiting ? ld_addr_q : ex_addr_lo;

    load_extend #(
        .W(CPU_WIDTH)
    ) u_ext (
        .dword_i   (mem_rdata),
        .type_i    (ext_type),
        .addr_lo_i (ext_addr),
        .data_o    (ext_data),
        .aligned_o (ext_aligned)
    );

    always_comb begin
        state_d     = state_q;
        ld_rd_d     = ld_rd_q;
        ld_type_d   = ld_type_q;
        ld_addr_d   = ld_addr_q;
        ld_wen_d    = ld_wen_q;
        reg_wen_d   = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        err_mis_d   = 1'b0;
        err_unexp_d = err_unexp_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_rvalid) begin
                    err_unexp_d = 1'b1;
                end
                if (accept && ex_is_load) begin
                    state_d   = ST_WAIT_LOAD;
                    ld_rd_d   = ex_rd;
                    ld_type_d = ex_load_type;
                    ld_addr_d = ex_addr_lo;
                    ld_wen_d  = ex_wen & (|ex_rd) & ext_aligned;
                    err_mis_d = ~ext_aligned;
                end else if (accept) begin
                    reg_wen_d   = ex_wen & (|ex_rd);
                    reg_waddr_d = ex_rd;
                    reg_wdata_d = ex_result;
                end
            end
            ST_WAIT_LOAD: begin
                if (mem_rvalid) begin
                    state_d     = ST_IDLE;
                    reg_wen_d   = ld_wen_q;
                    reg_waddr_d = ld_rd_q;
                    reg_wdata_d = ext_data;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ld_rd_q     <= '0;
            ld_type_q   <= '0;
            ld_addr_q   <= '0;
            ld_wen_q    <= 1'b0;
            reg_wen_q   <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            err_mis_q   <= 1'b0;
            err_unexp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_rd_q     <= ld_rd_d;
            ld_type_q   <= ld_type_d;
            ld_addr_q   <= ld_addr_d;
            ld_wen_q    <= ld_wen_d;
            reg_wen_q   <= reg_wen_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            err_mis_q   <= err_mis_d;
            err_unexp_q <= err_unexp_d;
        end
    end

    // ld_wen_q is already zero for x0 and misaligned loads.
    assign load_hazard   = waiting & ld_wen_q &
                           ((rs1_addr == ld_rd_q) | (rs2_addr == ld_rd_q));
    assign ex_ready      = ~waiting;
    assign reg_wen       = reg_wen_q;
    assign reg_waddr     = reg_waddr_q;
    assign reg_wdata     = reg_wdata_q;
    assign wmask         = reg_wen_q ? 8'hFF : 8'h00;
    assign err_misalign  = err_mis_q;
    assign err_unexp_rsp = err_unexp_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_wen;
    logic [4:0]  ex_rd;
    logic [63:0] ex_result;
    logic        ex_is_load;
    logic [2:0]  ex_load_type;
    logic [2:0]  ex_addr_lo;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        load_hazard;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [63:0] reg_wdata;
    logic [7:0]  wmask;
    logic        err_misalign;
    logic        err_unexp_rsp;

    always #5 clk = ~clk;

    wb_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_wen        (ex_wen),
        .ex_rd         (ex_rd),
        .ex_result     (ex_result),
        .ex_is_load    (ex_is_load),
        .ex_load_type  (ex_load_type),
        .ex_addr_lo    (ex_addr_lo),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .load_hazard   (load_hazard),
        .reg_wen       (reg_wen),
        .reg_waddr     (reg_waddr),
        .reg_wdata     (reg_wdata),
        .wmask         (wmask),
        .err_misalign  (err_misalign),
        .err_unexp_rsp (err_unexp_rsp)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: one pending load and the expected write port.
    bit        pend;
    bit [4:0]  p_rd;
    bit        p_wen;
    bit [2:0]  p_type;
    bit [2:0]  p_addr;
    bit        e_wen;
    bit [4:0]  e_waddr;
    bit [63:0] e_wdata;
    bit        e_mis;
    bit        e_unexp;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic int lsize(input bit [2:0] t);
        if (t[1:0] == 2'b11) return 8;
        return 1 << t[1:0];
    endfunction

    function automatic bit [63:0] lval(input bit [63:0] d, input bit [2:0] t,
                                       input bit [2:0] a);
        int        sz;
        bit [63:0] v;
        bit [63:0] m;
        sz = lsize(t);
        v  = d >> (int'(a) * 8);
        if (sz == 8) return v;
        m = (64'd1 << (sz * 8)) - 64'd1;
        v = v & m;
        if (!t[2] && v[sz*8-1]) v = v | ~m;
        return v;
    endfunction

    // Inputs are already applied; check combinational outputs, advance the
    // model across the coming edge, then check registered outputs.
    task automatic step();
        bit aligned;
        #1;
        chk("ex_ready", ex_ready, !pend);
        chk("load_hazard", load_hazard,
            pend && p_wen && (rs1_addr == p_rd || rs2_addr == p_rd));
        e_wen = 0;
        e_mis = 0;
        if (!pend) begin
            if (mem_rvalid) e_unexp = 1;
            if (ex_valid && ex_is_load) begin
                aligned = (int'(ex_addr_lo) % lsize(ex_load_type)) == 0;
                pend    = 1;
                p_rd    = ex_rd;
                p_type  = ex_load_type;
                p_addr  = ex_addr_lo;
                p_wen   = ex_wen && ex_rd != 0 && aligned;
                e_mis   = !aligned;
            end else if (ex_valid) begin
                e_wen   = ex_wen && ex_rd != 0;
                e_waddr = ex_rd;
                e_wdata = ex_result;
            end
        end else if (mem_rvalid) begin
            pend    = 0;
            e_wen   = p_wen;
            e_waddr = p_rd;
            e_wdata = lval(mem_rdata, p_type, p_addr);
        end
        @(negedge clk);
        chk("reg_wen", reg_wen, e_wen);
        chk("wmask", wmask, e_wen ? 8'hFF : 8'h00);
        chk("err_misalign", err_misalign, e_mis);
        chk("err_unexp_rsp", err_unexp_rsp, e_unexp);
        if (e_wen) begin
            chk("reg_waddr", reg_waddr, e_waddr);
            chk("reg_wdata", reg_wdata, e_wdata);
        end
    endtask

    task automatic idle();
        ex_valid     = 0;
        ex_wen       = 0;
        ex_rd        = 0;
        ex_result    = 0;
        ex_is_load   = 0;
        ex_load_type = 0;
        ex_addr_lo   = 0;
        mem_rvalid   = 0;
        mem_rdata    = 0;
        rs1_addr     = 0;
        rs2_addr     = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        #1;
        chk("rst_reg_wen", reg_wen, 0);
        chk("rst_reg_waddr", reg_waddr, 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_wmask", wmask, 0);
        chk("rst_err_misalign", err_misalign, 0);
        chk("rst_err_unexp", err_unexp_rsp, 0);
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_hazard", load_hazard, 0);
        pend    = 0;
        e_wen   = 0;
        e_mis   = 0;
        e_unexp = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic set_alu(input bit [4:0] rd, input bit [63:0] res);
        idle();
        ex_valid  = 1;
        ex_wen    = 1;
        ex_rd     = rd;
        ex_result = res;
    endtask

    task automatic set_load(input bit [4:0] rd, input bit [2:0] t,
                            input bit [2:0] a);
        idle();
        ex_valid     = 1;
        ex_wen       = 1;
        ex_is_load   = 1;
        ex_rd        = rd;
        ex_load_type = t;
        ex_addr_lo   = a;
    endtask

    task automatic set_rsp(input bit [63:0] d);
        idle();
        mem_rvalid = 1;
        mem_rdata  = d;
    endtask

    initial begin
        rst_n = 0;
        do_reset();

        // ALU write, one cycle later, for exactly one cycle.
        set_alu(5, 64'h1234);
        step();
        chk("tp_alu_wen", reg_wen, 1);
        chk("tp_alu_waddr", reg_waddr, 5);
        chk("tp_alu_wdata", reg_wdata, 64'h1234);
        chk("tp_alu_wmask", wmask, 8'hFF);
        idle();
        step();
        chk("tp_alu_wen_off", reg_wen, 0);

        // LB from byte 3, response four cycles after acceptance.
        set_load(7, 3'b000, 3);
        step();
        idle();
        rs1_addr = 7;
        repeat (3) begin
            #1;
            chk("tp_lb_hazard", load_hazard, 1);
            chk("tp_lb_ready", ex_ready, 0);
            step();
        end
        set_rsp(64'h0000_0000_8000_0000);
        rs1_addr = 7;
        step();
        chk("tp_lb_wen", reg_wen, 1);
        chk("tp_lb_waddr", reg_waddr, 7);
        chk("tp_lb_wdata", reg_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        idle();
        rs1_addr = 7;
        #1;
        chk("tp_lb_ready_after", ex_ready, 1);
        chk("tp_lb_hazard_after", load_hazard, 0);
        step();

        // LHU from the top halfword.
        set_load(3, 3'b101, 6);
        step();
        set_rsp(64'hBEEF_0000_0000_0000);
        step();
        chk("tp_lhu_wdata", reg_wdata, 64'h0000_0000_0000_BEEF);
        idle();
        step();

        // Misaligned LW: error pulse, response consumed, no write.
        set_load(9, 3'b010, 2);
        step();
        chk("tp_lw_mis", err_misalign, 1);
        idle();
        rs2_addr = 9;
        step();
        chk("tp_lw_mis_off", err_misalign, 0);
        set_rsp(64'h1122_3344_5566_7788);
        step();
        chk("tp_lw_nowen", reg_wen, 0);
        chk("tp_lw_ready", ex_ready, 1);

        // x0 destination: no write, no hazard.
        set_alu(0, 64'h55);
        step();
        chk("tp_x0_alu", reg_wen, 0);
        set_load(0, 3'b011, 0);
        step();
        idle();
        #1;
        chk("tp_x0_hazard", load_hazard, 0);
        step();
        set_rsp(64'hDEAD_BEEF_0000_0001);
        step();
        chk("tp_x0_load", reg_wen, 0);

        // Reset while a load is outstanding drops it.
        set_load(4, 3'b011, 0);
        step();
        idle();
        step();
        do_reset();
        set_rsp(64'hCAFE_F00D_1234_5678);
        step();
        chk("tp_rst_unexp", err_unexp_rsp, 1);
        chk("tp_rst_nowen", reg_wen, 0);
        idle();
        step();
        step();
        chk("tp_rst_unexp_held", err_unexp_rsp, 1);
        chk("tp_rst_ready", ex_ready, 1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            ex_valid     = $urandom_range(0, 1) == 1;
            ex_is_load   = $urandom_range(0, 4) < 2;
            ex_wen       = $urandom_range(0, 7) != 0;
            ex_rd        = 5'($urandom_range(0, 7));
            ex_result    = {$urandom, $urandom};
            ex_load_type = 3'($urandom_range(0, 7));
            ex_addr_lo   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) ex_addr_lo = 3'b000;
            mem_rvalid   = $urandom_range(0, 3) == 0;
            mem_rdata    = {$urandom, $urandom};
            rs1_addr     = 5'($urandom_range(0, 7));
            rs2_addr     = 5'($urandom_range(0, 7));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Writeback controller between the execute/LSU stage and the register file. Accepts one retiring instruction per handshake, registers its result, and drives the register-file write port (enable, address, data, mask). Holds a single outstanding load until the memory response arrives, then extracts and extends the load data. Reports a load-use hazard to decode while that load is outstanding.

## Interface
- `CPU_WIDTH`, default 64: data width, from the shared defines.
- `REG_ADDR_WIDTH`, default 5: register address width, from the shared defines.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: retiring instruction presented.
- `ex_ready` out 1: controller accepts the instruction this cycle.
- `ex_wen` in 1: instruction writes `rd`.
- `ex_rd` in REG_ADDR_WIDTH: destination register.
- `ex_result` in CPU_WIDTH: ALU result. Ignored for loads.
- `ex_is_load` in 1: instruction is a load.
- `ex_load_type` in 3: funct3 encoding. LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110.
- `ex_addr_lo` in 3: load address bits [2:0].
- `mem_rvalid` in 1: load response valid, one-cycle pulse.
- `mem_rdata` in CPU_WIDTH: aligned 64-bit doubleword containing the load data.
- `rs1_addr`, `rs2_addr` in REG_ADDR_WIDTH each: decode source registers.
- `load_hazard` out 1: decode must stall.
- `reg_wen` out 1: register-file write enable.
- `reg_waddr` out REG_ADDR_WIDTH: register-file write address.
- `reg_wdata` out CPU_WIDTH: register-file write data.
- `wmask` out 8: register-file write mask.
- `err_misalign` out 1: one-cycle pulse on acceptance of a misaligned load.
- `err_unexp_rsp` out 1: sticky flag; set by `mem_rvalid` while IDLE, cleared only by reset.

## Operation
- States:
  - IDLE: `ex_ready`=1.
  - WAIT_LOAD: `ex_ready`=0.
- Accept condition: `ex_valid & ex_ready`.
- Non-load accepted:
  - next cycle `reg_wen` = `ex_wen & (ex_rd!=0)`, `reg_waddr` = `ex_rd`, `reg_wdata` = `ex_result`.
  - State stays IDLE.
- Load accepted:
  - latch `rd`, load type, `addr_lo`, and the effective write enable.
  - Move to WAIT_LOAD.
  - Effective write enable = `ex_wen & (ex_rd!=0) & aligned`.
- Alignment rules:
  - H types need `addr_lo[0]`=0.
  - W types need `addr_lo[1:0]`=0.
  - LD needs `addr_lo`=0.
  - A misaligned load pulses `err_misalign` in the cycle after acceptance, still waits for its response, and writes nothing.
- WAIT_LOAD with `mem_rvalid`=1:
  - select byte, half or word at offset `addr_lo*8`.
  - Sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to 64 bits; LD passes through.
  - Register the write; return to IDLE.
- `wmask` = 8'hFF whenever `reg_wen`=1; otherwise 8'h00.
- `load_hazard` (combinational) = WAIT_LOAD & latched_wen & (`rs1_addr`==latched_rd | `rs2_addr`==latched_rd).
  - Never asserted for x0.
  - Deasserts in the cycle the response is accepted.
- `mem_rvalid` in IDLE is ignored except for setting `err_unexp_rsp`.
- `ex_load_type`=111 is treated as LD.

## Timing
- Reset values:
  - state IDLE; `ex_ready`=1.
  - `reg_wen`=0, `reg_waddr`=0, `reg_wdata`=0, `wmask`=0.
  - `load_hazard`=0, `err_misalign`=0, `err_unexp_rsp`=0.
- ALU latency: accept in cycle N → `reg_wen` high in N+1 for exactly one cycle.
- Load latency: response in cycle M (M ≥ N+1) → `reg_wen` high in M+1. `ex_ready`=1 in M+1.
  - A new instruction may be accepted in M+1; its write lands in M+2.
- Back-to-back ALU ops: one write per cycle, no bubbles.
- Reset asserted in WAIT_LOAD:
  - return to IDLE immediately; the pending load is dropped.
  - A later `mem_rvalid` sets `err_unexp_rsp`.
- `ex_*` inputs are sampled only on acceptance. Values presented while `ex_ready`=0 are ignored.

## Structure
- Shared defines (existing `rvseed_defines.v`) hold:
  - CPU_WIDTH, REG_ADDR_WIDTH.
  - Load funct3 constants (LB…LWU).
  - State encodings IDLE=1'b0, WAIT_LOAD=1'b1.
- One sub-module, `load_extend`: combinational.
  - Inputs: doubleword, type, `addr_lo`.
  - Outputs: extended 64-bit value and an aligned flag.
  - Instantiated once in `wb_ctrl`. The aligned-flag output is also used at acceptance.

## Test plan
- ALU op `rd`=5, result 0x1234 accepted at cycle 10 → cycle 11: `reg_wen`=1, `reg_waddr`=5, `reg_wdata`=0x1234, `wmask`=0xFF. Cycle 12: `reg_wen`=0.
- LB `rd`=7, `addr_lo`=3; `mem_rdata`=0x0000_0000_8000_0000; response 4 cycles later → `ex_ready`=0 and `load_hazard`=1 for `rs1_addr`=7 while waiting. Write 0xFFFF_FFFF_FFFF_FF80 one cycle after `mem_rvalid`.
- LHU `rd`=3, `addr_lo`=6, `mem_rdata`=0xBEEF_0000_0000_0000 → `reg_wdata`=0x0000_0000_0000_BEEF.
- LW `rd`=9, `addr_lo`=2 → `err_misalign` pulses the cycle after acceptance. The response is consumed; no `reg_wen`; state returns to IDLE.
- ALU op `rd`=0, and a load `rd`=0 → no `reg_wen`; `load_hazard` stays 0 with `rs1_addr`=0.
- `rst_n` low while in WAIT_LOAD, then `mem_rvalid` after release → no write; `err_unexp_rsp`=1 and held; `ex_ready`=1.
